pipe_fifo: RTL
==============

Name: pipe_fifo

Overview:
- Parameterised synchronous FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the datapath's resettable register stage.
- Absorbs bursts from a producer and presents one word per cycle on a registered-storage, first-word-fall-through output. The downstream flop stage samples that output.
- Single clock domain.

Parameters:
- WIDTH, 8, data word width in bits (matches downstream register width).
- DEPTH, 4, number of storage entries. Must be a power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; asserted when 0
- flush  input  1  synchronous clear of FIFO contents, active-high
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  FIFO can accept a word this cycle
- in_data  input  WIDTH  producer data
- out_valid  output  1  out_data holds the oldest stored word
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  oldest stored word; 0 when empty
- count  output  $clog2(DEPTH+1)  number of stored entries, 0..DEPTH

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low. reset=0 immediately forces the state below, independent of clk. Deassertion takes effect at the next rising edge.
- Reset state: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=0. Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at each rising edge.
- in_ready = (count != DEPTH). It depends only on registered state, never combinationally on out_ready. A push into a full FIFO is therefore refused even if a pop occurs the same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else 0.
- Latency: a word pushed at edge N appears on out_data (out_valid=1) after edge N if the FIFO was empty, i.e. one cycle in-to-out. There is no combinational in->out path.
- On push: mem[wr_ptr] <= in_data; wr_ptr increments modulo DEPTH.
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer compare.
- Full: in_ready=0; in_valid is ignored and data is dropped by the protocol. The producer must hold in_valid/in_data until in_ready.
- Empty: out_ready is ignored; count never underflows.
- flush=1 at an edge: pointers and count go to 0. Any same-cycle push or pop is discarded. flush has priority over push/pop; reset has priority over flush.
- Reset mid-operation: all stored words are lost. After deassertion the FIFO behaves as freshly reset.
- Producer rule: in_data must be stable while in_valid=1 and in_ready=0. The FIFO itself imposes no such rule on out_ready.

Decomposition:
- Package pipe_fifo_pkg holds:
  - DEFAULT_WIDTH=8 and DEFAULT_DEPTH=4
  - function clog2_cnt(depth) returning the count width
  - typedef fifo_status_t (packed struct: empty, full, count) for downstream debug/status buses
- One natural sub-module: pipe_fifo_ptr. It is a parameterised wrap-around pointer register with async active-low reset, a synchronous clear and an increment enable. It is instantiated twice (write and read pointer).
- Storage and count logic remain in pipe_fifo.

Test Plan:
1. Reset check: hold reset=0 mid-cycle -> out_valid=0, in_ready=1, count=0, out_data=8'h00 immediately, without waiting for clk.
2. Single word: push 8'hAA with out_ready=0 -> one edge later out_valid=1, out_data=8'hAA, count=1. Then out_ready=1 for one cycle -> out_valid=0, out_data=8'h00, count=0.
3. Fill, full and order:
   - Push 8'h11, 8'h22, 8'h33, 8'h44 with out_ready=0 -> count=4, in_ready=0.
   - Attempt push 8'h55 -> refused, count stays 4.
   - Drain -> out_data sequence 11, 22, 33, 44.
4. Simultaneous push/pop at count=2 holding 8'hA0, 8'hA1: push 8'hCC with out_ready=1 -> count stays 2, output advances to 8'hA1. Wrap test: run 10 continuous push/pop cycles -> data order preserved through pointer wrap-around.
5. Flush and reset priority:
   - With count=3, assert flush together with a push of 8'hFF -> next edge count=0, out_valid=0; 8'hFF is never output.
   - Assert reset=0 while count=2 -> state cleared asynchronously; a subsequent push of 8'hCC emerges alone as the first output.

Source files
------------

// File: rtl/pipe_fifo_pkg.sv
// Shared sizing defaults, count-width helper and status bundle for pipe_fifo.
package pipe_fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Count must represent 0..depth inclusive, hence depth+1 states.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_CW = $clog2(DEFAULT_DEPTH + 1);

  typedef struct packed {
    logic                  empty;
    logic                  full;
    logic [DEFAULT_CW-1:0] count;
  } fifo_status_t;

endpackage

// File: rtl/pipe_fifo_ptr.sv
// Wrap-around pointer register: async active-low reset, sync clear, increment enable.
module pipe_fifo_ptr
  import pipe_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // DEPTH is a power of two, so the natural binary rollover is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/pipe_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides; output read from registered storage.
module pipe_fifo
  import pipe_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = clog2_cnt(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  // Ready comes from count alone, so a full FIFO refuses a push even on a pop cycle.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  pipe_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  pipe_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is intentionally unreset; out_data is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            count <= '0;
    else if (flush)        count <= '0;
    else if (push && !pop) count <= count + 1'b1;
    else if (pop && !push) count <= count - 1'b1;
  end

endmodule
